mem_stride_fetcher: RTL and testbench

MEM_STRIDE_FETCHER -- requirements
Module: mem_stride_fetcher

---
 rtl/mem_stride_fetcher.sv | 159 +++++++++++++++
 tb/tb_mem_stride_fetcher.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stride_fetcher.sv
// rtl/mem_stride_fetcher.sv - strided line fetcher: memory read master feeding a ready/valid stream
// MEM_FETCH_SKID_EN: 2-entry output FIFO when defined, single-entry buffer otherwise.
module mem_stride_fetcher #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

`ifdef MEM_FETCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [0:0] LAST_PTR = 1'(DEPTH - 1);
  localparam logic [1:0] FULL_OCC = 2'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_stride;
  logic [LEN_W-1:0]  r_count;
  logic [LEN_W-1:0]  r_issued;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_buf_data [DEPTH];
  logic              r_buf_last [DEPTH];
  logic [0:0]        r_wr_ptr;
  logic [0:0]        r_rd_ptr;
  logic [1:0]        r_occ;

  logic w_push;
  logic w_pop;
  logic w_buf_free;
  logic w_lines_left;

  // mem_req is only ever high in S_REQ, so this also filters acks arriving outside a request
  assign w_push       = r_mem_req && mem_ack;
  assign w_pop        = out_valid && out_ready;
  assign w_buf_free   = r_occ < FULL_OCC;
  assign w_lines_left = r_issued != r_count;

  assign mem_data  = {DATA_W{1'bz}};
  assign mem_w_en  = 1'b0;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_occ != 2'd0;
  assign out_data  = r_buf_data[r_rd_ptr];
  assign out_last  = out_valid && r_buf_last[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_data[i] <= '0;
        r_buf_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= mem_data;
        r_buf_last[r_wr_ptr] <= (r_issued + 1'b1) == r_count;
        r_wr_ptr             <= (r_wr_ptr == LAST_PTR) ? 1'b0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? 1'b0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_stride   <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_stride   <= stride;
            r_count    <= count;
            r_issued   <= '0;
            r_mem_addr <= base_addr;
            r_busy     <= 1'b1;
            if (count == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state   <= S_REQ;
              r_mem_req <= 1'b1;
            end
          end else begin
            // busy stays up through the done pulse, which is emitted from IDLE
            r_busy <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_issued   <= r_issued + 1'b1;
            r_mem_addr <= r_mem_addr + r_stride;
            r_state    <= S_GAP;
          end
        end
        S_GAP: begin
          if (!w_lines_left) begin
            r_state <= S_DRAIN;
          end else if (w_buf_free) begin
            r_state   <= S_REQ;
            r_mem_req <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_occ == 2'd0) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stride_fetcher.sv
// tb/tb_mem_stride_fetcher.sv - randomized self-checking bench for mem_stride_fetcher
module tb_mem_stride_fetcher;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 8;
`ifdef MEM_FETCH_SKID_EN
  localparam int BUF_LINES = 2;
`else
  localparam int BUF_LINES = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] stride = '0;
  logic [LEN_W-1:0]  count = '0;
  logic              busy, done, mem_req, mem_w_en, out_valid, out_last;
  logic              mem_ack = 1'b0;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] mem_data_drv = '0;
  wire  [DATA_W-1:0] mem_data;

  assign mem_data = mem_data_drv;

  mem_stride_fetcher #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .stride(stride),
    .count(count), .busy(busy), .done(done), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_data(mem_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int ack_dly = 2;
  bit slave_en = 1'b1;
  bit spurious = 1'b0;
  int ready_mode = 0;
  int ready_hold = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int acks_at_release = -1;
  bit req_seen = 1'b0;
  logic [ADDR_W-1:0] q_addr[$];
  logic [DATA_W-1:0] q_sent[$];
  logic [DATA_W-1:0] q_rx[$];
  logic              q_last[$];

  function automatic logic [DATA_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // memory slave: acks ack_dly cycles after seeing a request, logs address and data in order
  initial begin : slave
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!reset_n) begin
        wait_cnt = 0;
      end else if (mem_req && slave_en) begin
        wait_cnt++;
        if (wait_cnt >= ack_dly) begin
          mem_ack = 1'b1;
          mem_data_drv = rand_line();
          q_addr.push_back(mem_addr);
          q_sent.push_back(mem_data_drv);
          ack_cnt++;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
        if (spurious && !mem_req && $urandom_range(0, 2) == 0) begin
          mem_ack = 1'b1;
          mem_data_drv = rand_line();
        end
      end
    end
  end

  initial begin : sink
    forever begin
      @(negedge clk);
      if (ready_hold > 0) begin
        out_ready = 1'b0;
        ready_hold--;
        if (ready_hold == 0) acks_at_release = ack_cnt;
      end else if (ready_mode == 1) begin
        out_ready = ($urandom_range(0, 1) == 1);
      end else begin
        out_ready = 1'b1;
      end
      if (reset_n && out_valid && out_ready) begin
        q_rx.push_back(out_data);
        q_last.push_back(out_last);
      end
      if (done) done_cnt++;
      if (mem_req) req_seen = 1'b1;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                         input logic [LEN_W-1:0] n, input int restart_at,
                         output logic req1, output int done_lat, output logic busy_done,
                         output logic busy_after, output bit timed_out);
    q_addr.delete(); q_sent.delete(); q_rx.delete(); q_last.delete();
    done_cnt = 0; ack_cnt = 0; req_seen = 1'b0;
    req1 = 1'b0; done_lat = -1; busy_done = 1'b0; busy_after = 1'b1; timed_out = 1'b1;
    @(negedge clk);
    base_addr = b; stride = s; count = n; start = 1'b1;
    for (int lat = 1; lat <= 3000; lat++) begin
      @(negedge clk);
      start = (lat == restart_at);
      if (start) begin
        base_addr = ADDR_W'($urandom());
        stride    = ADDR_W'($urandom());
        count     = LEN_W'(5);
      end
      if (lat == 1) req1 = mem_req;
      if (done) begin
        done_lat = lat;
        busy_done = busy;
        @(negedge clk);
        busy_after = busy;
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic req1; int lat; logic bd, ba; bit to;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mem_req, mem_w_en, busy, done, out_valid, out_last} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {mem_req, mem_w_en, busy, done, out_valid, out_last});
    end
    n_tests++;
    if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    n_tests++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    // reset asserted while the request is outstanding (slave holds off its ack)
    slave_en = 1'b0;
    base_addr = 16'h1234; stride = 16'h0010; count = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL midreq_pre: mem_req got %b expected 1", mem_req); end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({mem_req, out_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL midreq_async: {req,valid,busy} got %b expected 000", {mem_req, out_valid, busy});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    slave_en = 1'b1;
    done_cnt = 0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreq_after: done pulses %0d busy %b expected 0 0", done_cnt, busy);
    end
    run_cmd(16'h0100, 16'h0002, 8'd2, 0, req1, lat, bd, ba, to);
    n_tests++;
    if (to || q_rx.size() != 2 || q_addr.size() != 2 || q_addr[0] !== 16'h0100) begin
      n_fail++; $display("FAIL fresh_cmd: lines %0d timeout %0b expected 2 0", q_rx.size(), to);
    end
  endtask

  task automatic test_fetch_patterns();
    logic [ADDR_W-1:0] b, s, ea; logic [LEN_W-1:0] n;
    logic req1; int lat; logic bd, ba; bit to;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin b = 16'h0010; s = 16'h0004; n = 8'd3; end
      else if (k == 1) begin b = 16'hFFF8; s = 16'h0008; n = 8'd3; end
      else begin b = ADDR_W'($urandom()); s = ADDR_W'($urandom()); n = LEN_W'($urandom_range(1, 7)); end
      ack_dly = (k < 2) ? 2 : $urandom_range(1, 3);
      ready_mode = (k < 2) ? 0 : 1;
      run_cmd(b, s, n, 0, req1, lat, bd, ba, to);
      n_tests++;
      if (to || req1 !== 1'b1) begin n_fail++; $display("FAIL fetch%0d_start: req1 %b timeout %0b expected 1 0", k, req1, to); end
      n_tests++;
      if (done_cnt != 1 || {bd, ba} !== 2'b10) begin
        n_fail++; $display("FAIL fetch%0d_done: pulses %0d busy %b expected 1 10", k, done_cnt, {bd, ba});
      end
      n_tests++;
      if (q_addr.size() != int'(n) || q_rx.size() != int'(n)) begin
        n_fail++; $display("FAIL fetch%0d_count: reqs %0d lines %0d expected %0d", k, q_addr.size(), q_rx.size(), n);
      end
      for (int i = 0; i < q_addr.size(); i++) begin
        ea = b + ADDR_W'(i) * s;
        n_tests++;
        if (q_addr[i] !== ea) begin n_fail++; $display("FAIL fetch%0d_addr%0d: got %h expected %h", k, i, q_addr[i], ea); end
      end
      for (int i = 0; i < q_rx.size() && i < q_sent.size(); i++) begin
        n_tests++;
        if (q_rx[i] !== q_sent[i] || q_last[i] !== (i == int'(n) - 1)) begin
          n_fail++; $display("FAIL fetch%0d_line%0d: got %h last %b expected %h last %b",
                             k, i, q_rx[i], q_last[i], q_sent[i], (i == int'(n) - 1));
        end
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_backpressure();
    logic req1; int lat; logic bd, ba; bit to; int exp_acks;
    ack_dly = 1;
    ready_mode = 0;
    acks_at_release = -1;
    ready_hold = 20;
    exp_acks = (BUF_LINES < 4) ? BUF_LINES : 4;
    run_cmd(16'h2000, 16'h0040, 8'd4, 0, req1, lat, bd, ba, to);
    n_tests++;
    if (acks_at_release != exp_acks) begin
      n_fail++; $display("FAIL bp_acks: got %0d expected %0d", acks_at_release, exp_acks);
    end
    n_tests++;
    if (to || q_rx.size() != 4 || done_cnt != 1) begin
      n_fail++; $display("FAIL bp_count: lines %0d done %0d timeout %0b expected 4 1 0", q_rx.size(), done_cnt, to);
    end
    for (int i = 0; i < q_rx.size() && i < q_sent.size(); i++) begin
      n_tests++;
      if (q_rx[i] !== q_sent[i] || q_last[i] !== (i == 3)) begin
        n_fail++; $display("FAIL bp_line%0d: got %h last %b expected %h last %b", i, q_rx[i], q_last[i], q_sent[i], (i == 3));
      end
    end
  endtask

  task automatic test_zero_count();
    logic req1; int lat; logic bd, ba; bit to;
    ack_dly = 2;
    run_cmd(ADDR_W'($urandom()), ADDR_W'($urandom()), 8'd0, 0, req1, lat, bd, ba, to);
    n_tests++;
    if (to || lat != 2) begin n_fail++; $display("FAIL zero_lat: got %0d expected 2", lat); end
    n_tests++;
    if (req_seen || q_rx.size() != 0) begin
      n_fail++; $display("FAIL zero_req: mem_req seen %0b lines %0d expected 0 0", req_seen, q_rx.size());
    end
    n_tests++;
    if (done_cnt != 1 || {bd, ba} !== 2'b10) begin
      n_fail++; $display("FAIL zero_done: pulses %0d busy %b expected 1 10", done_cnt, {bd, ba});
    end
  endtask

  task automatic test_busy_start();
    logic req1; int lat; logic bd, ba; bit to; logic [ADDR_W-1:0] ea;
    ack_dly = 2;
    run_cmd(16'h0300, 16'h0020, 8'd3, 3, req1, lat, bd, ba, to);
    n_tests++;
    if (to || q_addr.size() != 3 || q_rx.size() != 3 || done_cnt != 1) begin
      n_fail++; $display("FAIL busy_start: reqs %0d lines %0d done %0d expected 3 3 1", q_addr.size(), q_rx.size(), done_cnt);
    end
    for (int i = 0; i < q_addr.size(); i++) begin
      ea = 16'h0300 + ADDR_W'(i) * 16'h0020;
      n_tests++;
      if (q_addr[i] !== ea) begin n_fail++; $display("FAIL busy_addr%0d: got %h expected %h", i, q_addr[i], ea); end
    end
  endtask

  task automatic test_spurious_and_coincident();
    logic [ADDR_W-1:0] b, s, ea; logic [LEN_W-1:0] n;
    logic req1; int lat; logic bd, ba; bit to;
    spurious = 1'b1;
    ready_mode = 1;
    for (int k = 0; k < 4; k++) begin
      b = ADDR_W'($urandom()); s = ADDR_W'($urandom()); n = LEN_W'($urandom_range(2, 8));
      ack_dly = $urandom_range(1, 2);
      run_cmd(b, s, n, 0, req1, lat, bd, ba, to);
      n_tests++;
      if (to || q_rx.size() != int'(n) || ack_cnt != int'(n) || done_cnt != 1) begin
        n_fail++; $display("FAIL spur%0d_count: lines %0d acks %0d done %0d expected %0d %0d 1",
                           k, q_rx.size(), ack_cnt, done_cnt, n, n);
      end
      for (int i = 0; i < q_rx.size() && i < q_sent.size() && i < q_addr.size(); i++) begin
        ea = b + ADDR_W'(i) * s;
        n_tests++;
        if (q_rx[i] !== q_sent[i] || q_last[i] !== (i == int'(n) - 1) || q_addr[i] !== ea) begin
          n_fail++; $display("FAIL spur%0d_line%0d: got %h/%h last %b expected %h/%h last %b", k, i,
                             q_addr[i], q_rx[i], q_last[i], ea, q_sent[i], (i == int'(n) - 1));
        end
      end
    end
    spurious = 1'b0;
    ready_mode = 0;
  endtask

  initial begin
    test_reset();
    test_fetch_patterns();
    test_backpressure();
    test_zero_count();
    test_busy_start();
    test_spurious_and_coincident();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
